// File: rtl/perf_pkg.sv
// Shared definitions for the performance monitor: readback map, FSM states,
// tag-model geometry and default run-termination limit.
package perf_pkg;

    localparam int IDX_W          = 6;
    localparam int TAG_W          = 22;
    localparam int NUM_ENT        = 1 << IDX_W;
    localparam int IDLE_LIMIT_DEF = 5;
    localparam int NUM_CNT        = 8;

    // Counter slots inside the packed counter array (match rd_sel 0..7).
    localparam int C_CYCLES   = 0;
    localparam int C_INSTRET  = 1;
    localparam int C_BRANCHES = 2;
    localparam int C_BR_MISS  = 3;
    localparam int C_IACC     = 4;
    localparam int C_IHIT     = 5;
    localparam int C_DACC     = 6;
    localparam int C_DHIT     = 7;

    // Readback select encodings.
    localparam logic [3:0] SEL_CYCLES   = 4'd0;
    localparam logic [3:0] SEL_INSTRET  = 4'd1;
    localparam logic [3:0] SEL_BRANCHES = 4'd2;
    localparam logic [3:0] SEL_BR_MISS  = 4'd3;
    localparam logic [3:0] SEL_IACC     = 4'd4;
    localparam logic [3:0] SEL_IHIT     = 4'd5;
    localparam logic [3:0] SEL_DACC     = 4'd6;
    localparam logic [3:0] SEL_DHIT     = 4'd7;
    localparam logic [3:0] SEL_STATUS   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Execute-stage control bundle of the instruction in Execute.
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic branch;
        logic jump;
        logic pc_src;
    } ex_ctrl_t;

endpackage

// File: rtl/perf_tag_model.sv
// 64-entry direct-mapped valid+tag array. Reports a hit when the indexed
// entry is valid with a matching tag; on a miss the entry is refilled.
module perf_tag_model
    import perf_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        access_en,
    input  logic [31:0] addr,
    output logic        access,
    output logic        hit
);

    logic [NUM_ENT-1:0] valid;
    logic [TAG_W-1:0]   tags [NUM_ENT];
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               unused_low;

    assign idx        = addr[IDX_W+3:4];
    assign tag        = addr[31:IDX_W+4];
    assign unused_low = ^addr[3:0];

    assign access = access_en;
    assign hit    = access_en && valid[idx] && (tags[idx] == tag);

    // Valid bits: cleared by reset/clear, set on a miss refill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            valid <= '0;
        else if (clear)
            valid <= '0;
        else if (access_en && !hit)
            valid[idx] <= 1'b1;
    end

    // Tag storage needs no reset; it is only consulted behind a valid bit.
    always_ff @(posedge clock) begin
        if (access_en && !hit)
            tags[idx] <= tag;
    end

endmodule

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: counts cycles, retired instructions, branches,
// mispredicts and I/D tag-model accesses/hits during a run that ends after
// IDLE_LIMIT consecutive idle Execute cycles. Counters saturate.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int IDLE_LIMIT = IDLE_LIMIT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic        ex_reg_write,
    input  logic        ex_mem_write,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic        ex_pc_src,
    input  logic [31:0] fetch_pc,
    input  logic        mem_write_m,
    input  logic        mem_read_m,
    input  logic [31:0] alu_result_m,
    input  logic [3:0]  rd_sel,
    output logic [31:0] rd_data,
    output logic        running,
    output logic        done
);

    localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);

    state_t                          state, state_next;
    ex_ctrl_t                        ex;
    logic [IDLE_W-1:0]               idle_cnt;
    logic [NUM_CNT-1:0][CNT_W-1:0]   cnt;
    logic [NUM_CNT-1:0]              inc;
    logic                            sample, active, idle_last, d_en;
    logic                            i_acc, i_hit, d_acc, d_hit;
    logic [CNT_W-1:0]                sel_cnt;
    logic [31:0]                     sel_word, rd_next;

    assign ex = '{reg_write: ex_reg_write, mem_write: ex_mem_write,
                  branch: ex_branch, jump: ex_jump, pc_src: ex_pc_src};

    assign running   = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign sample    = running && enable;
    assign active    = ex.reg_write || ex.mem_write || ex.branch || ex.jump;
    assign idle_last = !active && (idle_cnt == IDLE_W'(IDLE_LIMIT - 1));
    assign d_en      = sample && (mem_write_m || mem_read_m);

    perf_tag_model u_itag (
        .clock(clock), .reset(reset), .clear(clear),
        .access_en(sample), .addr(fetch_pc), .access(i_acc), .hit(i_hit)
    );

    perf_tag_model u_dtag (
        .clock(clock), .reset(reset), .clear(clear),
        .access_en(d_en), .addr(alu_result_m), .access(d_acc), .hit(d_hit)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state: clear wins, enable starts a run, idle streak ends it.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (enable) state_next = ST_RUN;
                ST_RUN:  if (sample && idle_last) state_next = ST_DONE;
                ST_DONE: state_next = ST_DONE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Consecutive-idle tracker; held whenever the edge is not sampled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            idle_cnt <= '0;
        else if (clear)
            idle_cnt <= '0;
        else if (sample) begin
            if (active)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_W'(IDLE_LIMIT))
                idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Per-counter increment requests for this edge.
    always_comb begin
        inc             = '0;
        inc[C_CYCLES]   = sample;
        inc[C_INSTRET]  = sample && active;
        inc[C_BRANCHES] = sample && ex.branch;
        inc[C_BR_MISS]  = sample && ex.branch && ex.pc_src;
        inc[C_IACC]     = i_acc;
        inc[C_IHIT]     = i_hit;
        inc[C_DACC]     = d_acc;
        inc[C_DHIT]     = d_hit;
    end

    // Saturating counters, each independent of the others.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else begin
            for (int k = 0; k < NUM_CNT; k++)
                if (inc[k] && (cnt[k] != '1))
                    cnt[k] <= cnt[k] + CNT_W'(1);
        end
    end

    // Readback select; in DONE the trailing idle cycles are removed from CYCLES.
    always_comb begin
        sel_cnt = '0;
        case (rd_sel)
            SEL_CYCLES:   sel_cnt = done ? (cnt[C_CYCLES] - CNT_W'(IDLE_LIMIT))
                                         : cnt[C_CYCLES];
            SEL_INSTRET:  sel_cnt = cnt[C_INSTRET];
            SEL_BRANCHES: sel_cnt = cnt[C_BRANCHES];
            SEL_BR_MISS:  sel_cnt = cnt[C_BR_MISS];
            SEL_IACC:     sel_cnt = cnt[C_IACC];
            SEL_IHIT:     sel_cnt = cnt[C_IHIT];
            SEL_DACC:     sel_cnt = cnt[C_DACC];
            SEL_DHIT:     sel_cnt = cnt[C_DHIT];
            default:      sel_cnt = '0;
        endcase
    end

    if (CNT_W > 32) begin : g_trunc
        logic unused_hi;
        assign unused_hi = ^sel_cnt[CNT_W-1:32];
        assign sel_word  = sel_cnt[31:0];
    end else if (CNT_W == 32) begin : g_same
        assign sel_word = sel_cnt;
    end else begin : g_zext
        assign sel_word = {{(32-CNT_W){1'b0}}, sel_cnt};
    end

    assign rd_next = (rd_sel == SEL_STATUS) ? {30'b0, done, running} : sel_word;

    // Registered read port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rd_data <= '0;
        else if (clear)
            rd_data <= '0;
        else
            rd_data <= rd_next;
    end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter IDLE_LIMIT, default 5: consecutive idle Execute cycles that end a measurement run.
REQ-002 Parameter CNT_W, default 32: width of every event counter.
REQ-003 Port clock, in, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, in, 1: asynchronous, active-low reset.
REQ-005 Port enable, in, 1: start/permit counting.
REQ-006 Port clear, in, 1: synchronous clear of all counters, tag models and state.
REQ-007 Ports ex_reg_write, ex_mem_write, ex_branch, ex_jump, ex_pc_src, in, 1 each: Execute-stage control of the instruction currently in Execute.
REQ-008 Port fetch_pc, in, 32: Fetch-stage PC.
REQ-009 Ports mem_write_m, mem_read_m, in, 1 each: Memory-stage store and load strobes.
REQ-010 Port alu_result_m, in, 32: Memory-stage data address.
REQ-011 Port rd_sel, in, 4: counter read select.
REQ-012 Port rd_data, out, 32: registered read data, zero-extended or truncated to 32 bits.
REQ-013 Ports running and done, out, 1 each: state flags.

Function
REQ-014 States: IDLE, RUN and DONE.
- IDLE -> RUN on the first edge with enable=1.
- RUN -> DONE on the edge where the idle count reaches IDLE_LIMIT.
- DONE holds until clear.
REQ-015 clear=1 forces IDLE on the next edge, zeroes all counters and the idle count, and invalidates all tag entries; clear has priority over every other event.
REQ-016 Events are sampled only on edges where state==RUN and enable=1. With enable=0 in RUN, nothing is counted and the idle count holds.
REQ-017 Cycle rule: CYCLES increments on every sampled edge.
REQ-018 Active-cycle rule: active = ex_reg_write | ex_mem_write | ex_branch | ex_jump.
- INSTRET increments when active=1.
- An active cycle resets the idle count to 0.
- An inactive cycle increments the idle count.
REQ-019 Branch rule: BRANCHES increments when ex_branch=1; BR_MISS increments when ex_branch=1 and ex_pc_src=1. Jumps never count as branches or mispredicts.
REQ-020 I-side tag model: IACC increments on every sampled edge.
- Index fetch_pc[9:4]; tag fetch_pc[31:10].
- Hit when the entry is valid and the tag matches; IHIT then increments.
- On a miss, the entry is made valid with the new tag on the same edge.
REQ-021 D-side tag model: identical to REQ-020 but indexed by alu_result_m, and evaluated only when mem_write_m | mem_read_m. Hits count in DHIT, accesses in DACC.
REQ-022 All counters saturate at all-ones and never wrap. Saturation of one counter does not affect the others.
REQ-023 In DONE, every counter is frozen, and the CYCLES read value is CYCLES-IDLE_LIMIT, so trailing idle cycles are excluded.
REQ-024 rd_data is valid one cycle after rd_sel is presented. Readback is allowed in every state.
- 0 CYCLES, 1 INSTRET, 2 BRANCHES, 3 BR_MISS.
- 4 IACC, 5 IHIT, 6 DACC, 7 DHIT.
- 8 STATUS = {30'b0, done, running}.
- 9-15 read 0.
REQ-025 running=1 exactly in RUN; done=1 exactly in DONE; both are derived directly from the state register.

Reset
REQ-026 With reset low, the block asynchronously enters IDLE:
- all counters and the idle count are 0;
- all valid bits are 0;
- rd_data, running and done are 0.
REQ-027 Reset asserted mid-RUN discards the run completely. After reset release, counting restarts only when enable=1 in IDLE.

Structure
REQ-028 Package perf_pkg holds:
- the rd_sel encodings;
- the state encoding;
- the index width (6) and tag width (22);
- the IDLE_LIMIT default.
REQ-029 Sub-module perf_tag_model, a 64-entry direct-mapped valid+tag array with access/hit outputs, is instantiated twice: I-side and D-side.

Verification
REQ-030 Reset with enable=1, then 10 active cycles (ex_reg_write=1), then 5 idle cycles:
- done rises on the 15th sampled edge;
- CYCLES=10, INSTRET=10.
REQ-031 Four branches with ex_pc_src pattern 0,1,0,1, plus one jump with ex_pc_src=1: BRANCHES=4, BR_MISS=2.
REQ-032 fetch_pc sequence 0x0, 0x4, 0x10, 0x0, 0x400 (same index as 0x0, different tag), 0x0: IACC=6, IHIT=2.
REQ-033 Loads to 0x100, 0x104, then 0x500, then 0x100: DACC=4, DHIT=1.
REQ-034 clear pulsed in DONE:
- next cycle: running=0, done=0, all reads 0;
- a repeat of address 0x0 then misses.
REQ-035 reset pulsed low mid-RUN after 3 active cycles: outputs are 0 immediately, before the next clock edge, and STATUS reads 0.
